// File: rtl/csa_pipe_addsub.sv
// csa_pipe_addsub
//   Pipelined carry-select adder/subtractor. Operands are cut into SEG-bit
//   segments. Each segment forms its sum for carry-in 0 and carry-in 1 in
//   parallel, and the incoming carry picks one of the two. A register
//   boundary follows every SEGS_PER_STAGE segments, which gives
//   STAGES = WIDTH/(SEG*SEGS_PER_STAGE) stages. Valid/ready on both sides
//   absorb downstream stalls. The pipeline holds at most STAGES beats.
//
//   WIDTH must be a multiple of SEG*SEGS_PER_STAGE.
//
//   Optional feature: define CSA_PIPE_SAT_EN to honour in_sat, which clamps
//   a signed overflow to the most positive or most negative value. Without
//   the macro, in_sat is ignored and no clamp logic is built.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (combinational from out_ready)
//   in_a/in_b  operands
//   in_sub     0: A+B, 1: A-B
//   in_sat     request signed saturation (CSA_PIPE_SAT_EN only)
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   out_sum    result
//   out_cout   carry out of MSB (subtraction: 1 = no borrow)
//   out_ovf    signed overflow
//   out_zero   out_sum == 0
module csa_pipe_addsub #(
  parameter int WIDTH          = 32,
  parameter int SEG            = 8,
  parameter int SEGS_PER_STAGE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SW     = SEG * SEGS_PER_STAGE;
  localparam int STAGES = WIDTH / SW;
  localparam int LAST   = STAGES - 1;

  // Stage k registers hold the beat after stage k has resolved its slice.
  // Operand bits travel with the beat; b_q holds the already-inverted B.
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] sat_q;
  logic              ovf_q;
  logic              zero_q;

  // Stage inputs: stage 0 from the ports, stage k from register k-1.
  logic [WIDTH-1:0]  a_src   [STAGES];
  logic [WIDTH-1:0]  b_src   [STAGES];
  logic [WIDTH-1:0]  s_src   [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] sat_src;
  logic [STAGES-1:0] v_src;

  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic              zero_d;
  logic [STAGES-1:0] take;

  always_comb begin
    a_src[0]   = in_a;
    b_src[0]   = in_sub ? ~in_b : in_b;
    s_src[0]   = '0;
    c_src[0]   = in_sub;
    sat_src[0] = in_sat;
    v_src[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      s_src[k]   = sum_q[k-1];
      c_src[k]   = c_q[k-1];
      sat_src[k] = sat_q[k-1];
      v_src[k]   = valid_q[k-1];
    end
  end

  // Stage k loads when it is empty or its content moves on this cycle.
  // Evaluated from the output end so a full pipeline advances in lockstep.
  always_comb begin
    take       = '0;
    take[LAST] = ~valid_q[LAST] | out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      take[k] = ~valid_q[k] | take[k+1];
    end
  end

  assign in_ready = take[0];

  always_comb begin
    logic [WIDTH-1:0] s;
    logic             c;
    logic [SEG-1:0]   sa;
    logic [SEG-1:0]   sb;
    logic [SEG:0]     r0;
    logic [SEG:0]     r1;
    logic [SEG:0]     r;
    logic             cin_msb;
    s       = '0;
    c       = 1'b0;
    sa      = '0;
    sb      = '0;
    r0      = '0;
    r1      = '0;
    r       = '0;
    cin_msb = 1'b0;
    c_d     = '0;
    for (int k = 0; k < STAGES; k++) begin
      s = s_src[k];
      c = c_src[k];
      for (int j = 0; j < SEGS_PER_STAGE; j++) begin
        sa = a_src[k][k*SW + j*SEG +: SEG];
        sb = b_src[k][k*SW + j*SEG +: SEG];
        r0 = {1'b0, sa} + {1'b0, sb};
        r1 = {1'b0, sa} + {1'b0, sb} + {{SEG{1'b0}}, 1'b1};
        // The lowest segment sees the true carry-in directly; all others select.
        if (k == 0 && j == 0) begin
          r = {1'b0, sa} + {1'b0, sb} + {{SEG{1'b0}}, c};
        end else begin
          r = c ? r1 : r0;
        end
        s[k*SW + j*SEG +: SEG] = r[SEG-1:0];
        c = r[SEG];
      end
      sum_d[k] = s;
      c_d[k]   = c;
    end

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    cin_msb = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1] ^ sum_d[LAST][WIDTH-1];
    ovf_d   = cin_msb ^ c_d[LAST];
`ifdef CSA_PIPE_SAT_EN
    if (sat_src[LAST] && ovf_d) begin
      sum_d[LAST] = a_src[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = (sum_d[LAST] == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      c_q     <= '0;
      sat_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (take[k]) begin
          valid_q[k] <= v_src[k];
          a_q[k]     <= a_src[k];
          b_q[k]     <= b_src[k];
          sum_q[k]   <= sum_d[k];
          c_q[k]     <= c_d[k];
          sat_q[k]   <= sat_src[k];
        end
      end
      if (take[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  // Operands and the saturation request are consumed before the last register.
  logic unused_tail;
  assign unused_tail = ^{a_q[LAST], b_q[LAST], sat_q[LAST]};

  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule
